// File: rtl/pix_seq_pkg.sv
// Shared definitions for the pixel sequencer: pixel-mode encodings,
// default sizes, sequencer state codes and the word-packing helper.
package pix_seq_pkg;

  localparam logic [1:0] PM_CRY16    = 2'd0;
  localparam logic [1:0] PM_RGB24    = 2'd1;
  localparam logic [1:0] PM_DIRECT16 = 2'd2;
  localparam logic [1:0] PM_RGB16    = 2'd3;

  localparam int LB_WORDS_DEF = 360;
  localparam int PW_BITS_DEF  = 3;

  // Sequencer states: idle between lines, active inside the hde span.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACT  = 1'b1;

  // Every mode except RGB24 packs two 16-bit pixels into one 32-bit word.
  function automatic logic is_wide(input logic [1:0] pm);
    return (pm != PM_RGB24);
  endfunction

endpackage

// File: rtl/pix_seq_if.sv
// Timing bus between the video timing source and the pixel sequencer.
// Strobe semantics: there is no valid/ready handshake. The master drives
// vclk/dd/hde/pwidth/pmode; the slave samples them only on vclk rising
// edges and returns pp/nextpixa/nextpixd as single-tick strobes, with
// word2/wide/lbovf as levels that hold between ticks.
interface pix_seq_if #(parameter int PW_BITS = 3);

  logic               vclk;
  logic               dd;
  logic               hde;
  logic [PW_BITS-1:0] pwidth;
  logic [1:0]         pmode;

  logic               pp;
  logic               nextpixa;
  logic               nextpixd;
  logic               word2;
  logic               wide;
  logic               lbovf;
  logic               seq_state;

  modport master (
    output vclk, dd, hde, pwidth, pmode,
    input  pp, nextpixa, nextpixd, word2, wide, lbovf, seq_state
  );

  modport slave (
    input  vclk, dd, hde, pwidth, pmode,
    output pp, nextpixa, nextpixd, word2, wide, lbovf, seq_state
  );

endinterface

// File: rtl/pix_seq_div.sv
// Tick-driven pixel-period divider: counts 0..limit and flags the
// boundary tick. Shared with border/blank timing.
module pix_seq_div #(
  parameter int W = 3
) (
  input  logic         sys_clk,
  input  logic         resetl,
  input  logic         tick,
  input  logic         clr,
  input  logic         run,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         boundary
);

  assign boundary = (cnt == limit);

  // Count on each tick while running, wrap at the boundary, clear on request.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      cnt <= '0;
    end else if (tick) begin
      if (clr)
        cnt <= '0;
      else if (run)
        cnt <= boundary ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pix_seq.sv
// Pixel sequencer: produces pixel pulse, line-buffer fetch strobes and
// half-word select from hde, the latched pixel width and pixel mode,
// advancing only on vclk rising edges seen in the sys_clk domain.
module pix_seq
  import pix_seq_pkg::*;
#(
  parameter int LB_WORDS = LB_WORDS_DEF,
  parameter int PW_BITS  = PW_BITS_DEF
) (
  input logic        sys_clk,
  input logic        resetl,
  pix_seq_if.slave   bus
);

  localparam int WC_W = $clog2(LB_WORDS + 1);
  localparam logic [WC_W-1:0] LB_MAX = WC_W'(LB_WORDS);

  logic               old_vclk;
  logic               tick;
  logic [0:0]         st_q;
  logic [1:0]         pmode_l;
  logic [PW_BITS-1:0] pwidth_l;
  logic               phase_q;
  logic [WC_W-1:0]    wcnt_q;
  logic               pp_q;
  logic               np_q;
  logic               word2_q;
  logic               lbovf_q;

  logic               wide_l;
  logic               clr_line;
  logic               start;
  logic               run;
  logic [PW_BITS-1:0] pcnt;
  logic               boundary;
  logic               phase_nx;
  logic               new_word;
  logic               fetch_ok;

  // Previous vclk sample for rising-edge detection.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl)
      old_vclk <= 1'b0;
    else
      old_vclk <= bus.vclk;
  end

  assign tick     = bus.vclk & ~old_vclk;
  assign wide_l   = is_wide(pmode_l);
  // dd and a dropped hde share the same line clear; dd wins regardless of hde.
  assign clr_line = bus.dd | ~bus.hde;
  assign start    = ~clr_line & (st_q == ST_IDLE);
  assign run      = ~clr_line & (st_q == ST_ACT);
  // Phase only toggles for two-pixel words; it stays 0 in RGB24.
  assign phase_nx = (boundary & wide_l) ? ~phase_q : phase_q;
  assign new_word = boundary & (~wide_l | ~phase_nx);
  assign fetch_ok = (wcnt_q < LB_MAX);

  pix_seq_div #(.W(PW_BITS)) u_div (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .tick     (tick),
    .clr      (clr_line | start),
    .run      (run),
    .limit    (pwidth_l),
    .cnt      (pcnt),
    .boundary (boundary)
  );

  // Line state, mode latch, word/phase tracking and strobe generation per tick.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      st_q     <= ST_IDLE;
      pmode_l  <= PM_RGB24;
      pwidth_l <= '0;
      phase_q  <= 1'b0;
      wcnt_q   <= '0;
      pp_q     <= 1'b0;
      np_q     <= 1'b0;
      word2_q  <= 1'b0;
      lbovf_q  <= 1'b0;
    end else if (tick) begin
      if (clr_line) begin
        st_q    <= ST_IDLE;
        phase_q <= 1'b0;
        wcnt_q  <= '0;
        pp_q    <= 1'b0;
        np_q    <= 1'b0;
        word2_q <= 1'b0;
        lbovf_q <= 1'b0;
      end else if (start) begin
        st_q     <= ST_ACT;
        pmode_l  <= bus.pmode;
        pwidth_l <= bus.pwidth;
        phase_q  <= 1'b0;
        wcnt_q   <= WC_W'(1);
        pp_q     <= 1'b1;
        np_q     <= 1'b1;
        word2_q  <= is_wide(bus.pmode);
      end else begin
        pp_q    <= boundary;
        phase_q <= phase_nx;
        word2_q <= wide_l & ~phase_nx;
        if (new_word && fetch_ok) begin
          np_q   <= 1'b1;
          wcnt_q <= wcnt_q + WC_W'(1);
        end else begin
          np_q <= 1'b0;
        end
        if (new_word && !fetch_ok)
          lbovf_q <= 1'b1;
      end
    end
  end

  assign bus.pp        = pp_q;
  assign bus.nextpixa  = np_q;
  assign bus.nextpixd  = np_q;
  assign bus.word2     = word2_q;
  assign bus.wide      = wide_l;
  assign bus.lbovf     = lbovf_q;
  assign bus.seq_state = st_q;

endmodule

// File: tb/tb_pix_seq.sv
// Directed bench for pix_seq. Two instances share the same timing inputs:
// dut_a with the default line-buffer size, dut_b with LB_WORDS=2 to reach
// the fetch limit. Observed vector order: {pp,nextpixa,nextpixd,word2,wide,lbovf}.
module tb_pix_seq;
  import pix_seq_pkg::*;

  logic sys_clk;
  logic resetl;
  int   n_cmp;
  int   n_bad;

  pix_seq_if #(.PW_BITS(3)) bus_a ();
  pix_seq_if #(.PW_BITS(3)) bus_b ();

  assign bus_b.vclk   = bus_a.vclk;
  assign bus_b.dd     = bus_a.dd;
  assign bus_b.hde    = bus_a.hde;
  assign bus_b.pwidth = bus_a.pwidth;
  assign bus_b.pmode  = bus_a.pmode;

  pix_seq #(.PW_BITS(3)) dut_a (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus_a)
  );

  pix_seq #(.LB_WORDS(2), .PW_BITS(3)) dut_b (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .bus     (bus_b)
  );

  logic [5:0] obs_a;
  logic [5:0] obs_b;
  assign obs_a = {bus_a.pp, bus_a.nextpixa, bus_a.nextpixd, bus_a.word2, bus_a.wide, bus_a.lbovf};
  assign obs_b = {bus_b.pp, bus_b.nextpixa, bus_b.nextpixd, bus_b.word2, bus_b.wide, bus_b.lbovf};

  // Clock and reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hand-computed expectations
  logic [5:0] exp_cry16 [8] = '{6'b111110, 6'b100010, 6'b111110, 6'b100010,
                                6'b111110, 6'b100010, 6'b111110, 6'b100010};
  logic [5:0] exp_rgb16 [16] = '{6'b111110, 6'b000110, 6'b100010, 6'b000010,
                                 6'b111110, 6'b000110, 6'b100010, 6'b000010,
                                 6'b100111, 6'b000111, 6'b100011, 6'b000011,
                                 6'b100111, 6'b000111, 6'b100011, 6'b000011};

  task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One vclk tick: rising edge seen at the next sys_clk edge; returns on a
  // falling sys_clk edge with outputs settled.
  task automatic vtick(input logic h, input logic d);
    @(negedge sys_clk);
    bus_a.hde  = h;
    bus_a.dd   = d;
    bus_a.vclk = 1'b1;
    @(negedge sys_clk);
    bus_a.vclk = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    resetl       = 1'b0;
    bus_a.vclk   = 1'b0;
    bus_a.dd     = 1'b0;
    bus_a.hde    = 1'b0;
    bus_a.pwidth = 3'd0;
    bus_a.pmode  = PM_RGB24;
    repeat (3) @(negedge sys_clk);
    check_val("reset_a", obs_a, 6'b000000);
    check_val("reset_b", obs_b, 6'b000000);
    resetl = 1'b1;
    repeat (2) @(negedge sys_clk);

    // CRY16, pwidth=0: pixel every tick, word every other tick
    bus_a.pmode  = PM_CRY16;
    bus_a.pwidth = 3'd0;
    for (int i = 0; i < 8; i++) begin
      vtick(1'b1, 1'b0);
      check_val($sformatf("cry16_t%0d", i), obs_a, exp_cry16[i]);
    end
    vtick(1'b0, 1'b0);
    check_val("cry16_end", obs_a, 6'b000010);

    // RGB24, pwidth=3: pixel and word every fourth tick
    bus_a.pmode  = PM_RGB24;
    bus_a.pwidth = 3'd3;
    for (int i = 0; i < 12; i++) begin
      vtick(1'b1, 1'b0);
      check_val($sformatf("rgb24_t%0d", i), obs_a, (i % 4 == 0) ? 6'b111000 : 6'b000000);
    end
    vtick(1'b0, 1'b0);
    check_val("rgb24_end", obs_a, 6'b000000);

    // RGB16, pwidth=1: dut_b runs out of line-buffer words at tick 8
    bus_a.pmode  = PM_RGB16;
    bus_a.pwidth = 3'd1;
    for (int i = 0; i < 16; i++) begin
      vtick(1'b1, 1'b0);
      check_val($sformatf("rgb16_b_t%0d", i), obs_b, exp_rgb16[i]);
      if (i == 8)
        check_val("rgb16_a_t8", obs_a, 6'b111110);
    end
    vtick(1'b0, 1'b0);
    check_val("rgb16_b_end", obs_b, 6'b000010);

    // pwidth change mid-line is ignored until the next start
    bus_a.pmode  = PM_RGB24;
    bus_a.pwidth = 3'd0;
    vtick(1'b1, 1'b0);
    check_val("pwchg_t0", obs_a, 6'b111000);
    bus_a.pwidth = 3'd5;
    for (int i = 1; i < 4; i++) begin
      vtick(1'b1, 1'b0);
      check_val($sformatf("pwchg_t%0d", i), obs_a, 6'b111000);
    end
    vtick(1'b0, 1'b0);
    check_val("pwchg_end", obs_a, 6'b000000);
    for (int i = 0; i < 7; i++) begin
      vtick(1'b1, 1'b0);
      check_val($sformatf("pw5_t%0d", i), obs_a, (i == 0 || i == 6) ? 6'b111000 : 6'b000000);
    end
    vtick(1'b0, 1'b0);

    // hde falls mid-pixel, then rises three ticks later; dd restart
    bus_a.pwidth = 3'd4;
    vtick(1'b1, 1'b0);
    check_val("fall_t0", obs_a, 6'b111000);
    vtick(1'b1, 1'b0);
    vtick(1'b1, 1'b0);
    vtick(1'b0, 1'b0);
    check_val("fall_tick", obs_a, 6'b000000);
    vtick(1'b0, 1'b0);
    vtick(1'b0, 1'b0);
    vtick(1'b1, 1'b0);
    check_val("rise_tick", obs_a, 6'b111000);
    for (int i = 1; i < 5; i++)
      vtick(1'b1, 1'b0);
    check_val("rise_t4", obs_a, 6'b000000);
    vtick(1'b1, 1'b0);
    check_val("rise_t5", obs_a, 6'b111000);
    vtick(1'b1, 1'b1);
    check_val("dd_clear", obs_a, 6'b000000);
    vtick(1'b1, 1'b0);
    check_val("dd_restart", obs_a, 6'b111000);
    vtick(1'b0, 1'b0);

    // Async reset mid-line, then vclk frozen
    bus_a.pmode  = PM_CRY16;
    bus_a.pwidth = 3'd2;
    vtick(1'b1, 1'b0);
    check_val("prerst", obs_a, 6'b111110);
    @(negedge sys_clk);
    #2 resetl = 1'b0;
    #1 check_val("rst_async", obs_a, 6'b000000);
    @(negedge sys_clk);
    resetl = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_val("rst_hold", obs_a, 6'b000000);
    vtick(1'b1, 1'b0);
    check_val("rst_restart", obs_a, 6'b111110);
    repeat (50) @(negedge sys_clk);
    check_val("freeze", obs_a, 6'b111110);
    vtick(1'b1, 1'b0);
    check_val("post_freeze", obs_a, 6'b000110);
    vtick(1'b0, 1'b0);
    check_val("final_idle", obs_a, 6'b000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
